// File: rtl/dispatch_stage_if.sv
// Signal bundle between the dispatch stage, its upstream queue, the ROB,
// the reservation stations and the CDB. The stage itself uses the slave side.
interface dispatch_stage_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int N_RS  = 4,
    parameter int N_CDB = 4,
    parameter int PAY_W = 96,
    parameter int CNT_W = 16
);
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [N_RS-1:0]        in_rs_sel;
    logic [TAG_W-1:0]       in_rob_tag;
    logic                   in_src1_busy;
    logic                   in_src2_busy;
    logic [XLEN-1:0]        in_src1_val;
    logic [XLEN-1:0]        in_src2_val;
    logic [TAG_W-1:0]       in_src1_tag;
    logic [TAG_W-1:0]       in_src2_tag;
    logic [PAY_W-1:0]       in_payload;
    logic                   rob_full;
    logic [N_RS-1:0]        rs_full;
    logic [N_CDB-1:0]       cdb_valid;
    logic [N_CDB*TAG_W-1:0] cdb_tag;
    logic [N_CDB*XLEN-1:0]  cdb_value;
    logic [N_RS-1:0]        disp_valid;
    logic [TAG_W-1:0]       disp_rob_tag;
    logic                   disp_src1_busy;
    logic                   disp_src2_busy;
    logic [XLEN-1:0]        disp_src1_val;
    logic [XLEN-1:0]        disp_src2_val;
    logic [TAG_W-1:0]       disp_src1_tag;
    logic [TAG_W-1:0]       disp_src2_tag;
    logic [PAY_W-1:0]       disp_payload;
    logic                   rob_alloc;
    logic [CNT_W-1:0]       stall_cnt;

    modport slave (
        input  flush, in_valid, in_rs_sel, in_rob_tag,
               in_src1_busy, in_src2_busy, in_src1_val, in_src2_val,
               in_src1_tag, in_src2_tag, in_payload,
               rob_full, rs_full, cdb_valid, cdb_tag, cdb_value,
        output in_ready, disp_valid, disp_rob_tag,
               disp_src1_busy, disp_src2_busy, disp_src1_val, disp_src2_val,
               disp_src1_tag, disp_src2_tag, disp_payload, rob_alloc, stall_cnt
    );

    modport master (
        output flush, in_valid, in_rs_sel, in_rob_tag,
               in_src1_busy, in_src2_busy, in_src1_val, in_src2_val,
               in_src1_tag, in_src2_tag, in_payload,
               rob_full, rs_full, cdb_valid, cdb_tag, cdb_value,
        input  in_ready, disp_valid, disp_rob_tag,
               disp_src1_busy, disp_src2_busy, disp_src1_val, disp_src2_val,
               disp_src1_tag, disp_src2_tag, disp_payload, rob_alloc, stall_cnt
    );
endinterface

// File: rtl/dispatch_stage.sv
// Registered rename/dispatch stage: one-entry holding register that snoops the
// CDB while blocked, then dispatches one-hot to a reservation station.
module dispatch_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int N_RS  = 4,
    parameter int N_CDB = 4,
    parameter int PAY_W = 96,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    dispatch_stage_if.slave  bus
);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] HELD  = 1'b1;

    typedef struct packed {
        logic             busy;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  val;
    } operand_t;

    logic [0:0]       state_q, state_d;
    logic [N_RS-1:0]  sel_q, sel_d;
    logic [TAG_W-1:0] rob_tag_q, rob_tag_d;
    operand_t         src1_q, src1_d, src2_q, src2_d;
    logic [PAY_W-1:0] payload_q, payload_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic     held, blocked, go, accept, disp_en;
    operand_t in_src1, in_src2, held_src1, held_src2;

    // Descending scan so the lowest-index matching port is the last writer.
    function automatic operand_t wake(
        input operand_t               op,
        input logic [N_CDB-1:0]       v,
        input logic [N_CDB*TAG_W-1:0] tags,
        input logic [N_CDB*XLEN-1:0]  vals
    );
        operand_t r;
        r = op;
        if (op.busy) begin
            for (int i = N_CDB - 1; i >= 0; i--) begin
                if (v[i] && (tags[i*TAG_W +: TAG_W] == op.tag)) begin
                    r.busy = 1'b0;
                    r.val  = vals[i*XLEN +: XLEN];
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        held      = (state_q == HELD);
        blocked   = bus.rob_full | (|(sel_q & bus.rs_full));
        go        = held & ~blocked & ~bus.flush;
        accept    = bus.in_valid & (~held | go) & ~bus.flush;
        disp_en   = go & (|sel_q);
        in_src1   = wake(operand_t'({bus.in_src1_busy, bus.in_src1_tag, bus.in_src1_val}),
                         bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        in_src2   = wake(operand_t'({bus.in_src2_busy, bus.in_src2_tag, bus.in_src2_val}),
                         bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        held_src1 = wake(src1_q, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        held_src2 = wake(src2_q, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
    end

    // NOTE: every always_comb target is given a default before any branch so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rob_tag_d   = rob_tag_q;
        payload_d   = payload_q;
        src1_d      = held_src1;
        src2_d      = held_src2;
        stall_cnt_d = stall_cnt_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d   = HELD;
            sel_d     = bus.in_rs_sel;
            rob_tag_d = bus.in_rob_tag;
            payload_d = bus.in_payload;
            src1_d    = in_src1;
            src2_d    = in_src2;
        end else if (go) begin
            state_d = EMPTY;
        end
        if (held && blocked && !bus.flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            sel_q       <= '0;
            rob_tag_q   <= '0;
            payload_q   <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rob_tag_q   <= rob_tag_d;
            payload_q   <= payload_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Operand outputs bypass the current CDB so a wakeup in the dispatch cycle is kept.
    assign bus.in_ready       = ~held | go;
    assign bus.disp_valid     = go ? sel_q : '0;
    assign bus.rob_alloc      = disp_en;
    assign bus.disp_rob_tag   = disp_en ? rob_tag_q : '0;
    assign bus.disp_payload   = disp_en ? payload_q : '0;
    assign bus.disp_src1_busy = disp_en & held_src1.busy;
    assign bus.disp_src2_busy = disp_en & held_src2.busy;
    assign bus.disp_src1_val  = disp_en ? held_src1.val : '0;
    assign bus.disp_src2_val  = disp_en ? held_src2.val : '0;
    assign bus.disp_src1_tag  = disp_en ? held_src1.tag : '0;
    assign bus.disp_src2_tag  = disp_en ? held_src2.tag : '0;
    assign bus.stall_cnt      = stall_cnt_q;
endmodule

// File: tb/tb_dispatch_stage.sv
// Directed plus randomized bench for dispatch_stage against a transaction-level
// model of the holding register (one optional instruction record).
module tb_dispatch_stage;
    localparam int XLEN  = 32;
    localparam int TAG_W = 4;
    localparam int N_RS  = 4;
    localparam int N_CDB = 4;
    localparam int PAY_W = 96;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dispatch_stage_if #(.XLEN(XLEN), .TAG_W(TAG_W), .N_RS(N_RS), .N_CDB(N_CDB),
                        .PAY_W(PAY_W), .CNT_W(CNT_W)) bus ();

    dispatch_stage #(.XLEN(XLEN), .TAG_W(TAG_W), .N_RS(N_RS), .N_CDB(N_CDB),
                     .PAY_W(PAY_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit               valid;
        logic [N_RS-1:0]  sel;
        logic [TAG_W-1:0] rob_tag;
        logic             b1;
        logic [TAG_W-1:0] t1;
        logic [XLEN-1:0]  v1;
        logic             b2;
        logic [TAG_W-1:0] t2;
        logic [XLEN-1:0]  v2;
        logic [PAY_W-1:0] pay;
    } instr_t;

    instr_t m, m_next;
    int cnt, cnt_next;
    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int first_hit(input logic [TAG_W-1:0] t);
        for (int i = 0; i < N_CDB; i++) begin
            if (bus.cdb_valid[i] && bus.cdb_tag[i*TAG_W +: TAG_W] == t) return i;
        end
        return -1;
    endfunction

    function automatic instr_t wake_instr(input instr_t x);
        instr_t r;
        int k;
        r = x;
        if (r.b1) begin
            k = first_hit(r.t1);
            if (k >= 0) begin r.b1 = 1'b0; r.v1 = bus.cdb_value[k*XLEN +: XLEN]; end
        end
        if (r.b2) begin
            k = first_hit(r.t2);
            if (k >= 0) begin r.b2 = 1'b0; r.v2 = bus.cdb_value[k*XLEN +: XLEN]; end
        end
        return r;
    endfunction

    task automatic set_idle();
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_rs_sel = '0; bus.in_rob_tag = '0;
        bus.in_src1_busy = 1'b0; bus.in_src2_busy = 1'b0;
        bus.in_src1_val = '0; bus.in_src2_val = '0;
        bus.in_src1_tag = '0; bus.in_src2_tag = '0; bus.in_payload = '0;
        bus.rob_full = 1'b0; bus.rs_full = '0;
        bus.cdb_valid = '0; bus.cdb_tag = '0; bus.cdb_value = '0;
    endtask

    task automatic load(input logic [N_RS-1:0] sel, input logic [TAG_W-1:0] tag,
                        input logic b1, input logic [TAG_W-1:0] t1, input logic [XLEN-1:0] v1,
                        input logic b2, input logic [TAG_W-1:0] t2, input logic [XLEN-1:0] v2);
        bus.in_valid = 1'b1; bus.in_rs_sel = sel; bus.in_rob_tag = tag;
        bus.in_src1_busy = b1; bus.in_src1_tag = t1; bus.in_src1_val = v1;
        bus.in_src2_busy = b2; bus.in_src2_tag = t2; bus.in_src2_val = v2;
        bus.in_payload = {$urandom, $urandom, $urandom};
    endtask

    // Compare every output against the model, then work out the model's next state.
    task automatic settle();
        logic blocked, go, en, rdy;
        instr_t h, c;
        #1;
        blocked = bus.rob_full || ((m.sel & bus.rs_full) != '0);
        go  = m.valid && !blocked && !bus.flush;
        en  = go && (m.sel != '0);
        rdy = !m.valid || go;
        h   = wake_instr(m);
        check("in_ready",   128'(bus.in_ready),       128'(rdy));
        check("disp_valid", 128'(bus.disp_valid),     128'(go ? m.sel : '0));
        check("rob_alloc",  128'(bus.rob_alloc),      128'(en));
        check("rob_tag",    128'(bus.disp_rob_tag),   128'(en ? h.rob_tag : '0));
        check("src1_busy",  128'(bus.disp_src1_busy), 128'(en & h.b1));
        check("src1_val",   128'(bus.disp_src1_val),  128'(en ? h.v1 : '0));
        check("src1_tag",   128'(bus.disp_src1_tag),  128'(en ? h.t1 : '0));
        check("src2_busy",  128'(bus.disp_src2_busy), 128'(en & h.b2));
        check("src2_val",   128'(bus.disp_src2_val),  128'(en ? h.v2 : '0));
        check("src2_tag",   128'(bus.disp_src2_tag),  128'(en ? h.t2 : '0));
        check("payload",    128'(bus.disp_payload),   128'(en ? h.pay : '0));
        check("stall_cnt",  128'(bus.stall_cnt),      128'(cnt));
        cnt_next = (m.valid && blocked && !bus.flush && cnt < CNT_MAX) ? cnt + 1 : cnt;
        if (bus.flush) begin
            m_next = m; m_next.valid = 1'b0;
        end else if (bus.in_valid && rdy) begin
            c.valid = 1'b1; c.sel = bus.in_rs_sel; c.rob_tag = bus.in_rob_tag;
            c.b1 = bus.in_src1_busy; c.t1 = bus.in_src1_tag; c.v1 = bus.in_src1_val;
            c.b2 = bus.in_src2_busy; c.t2 = bus.in_src2_tag; c.v2 = bus.in_src2_val;
            c.pay = bus.in_payload;
            m_next = wake_instr(c);
        end else if (go) begin
            m_next = m; m_next.valid = 1'b0;
        end else begin
            m_next = h;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m = m_next;
        cnt = cnt_next;
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        set_idle();
        m = '{default: '0};
        cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        settle();
        check("rst_ready", 128'(bus.in_ready), 128'(1));
        check("rst_dv",    128'(bus.disp_valid), 128'(0));
        check("rst_stall", 128'(bus.stall_cnt), 128'(0));
        tick();

        // Simple accept and dispatch
        load(4'b0010, 4'd5, 1'b0, 4'd0, 32'h1234, 1'b0, 4'd0, 32'h5678);
        settle(); tick();
        set_idle();
        settle();
        check("b_dv",    128'(bus.disp_valid), 128'(4'b0010));
        check("b_alloc", 128'(bus.rob_alloc), 128'(1));
        check("b_tag",   128'(bus.disp_rob_tag), 128'(5));
        tick();
        settle();
        check("b_empty_dv",  128'(bus.disp_valid), 128'(0));
        check("b_empty_rdy", 128'(bus.in_ready), 128'(1));
        tick();

        // Blocked on rs_full[1], wakeup from CDB port 2 while held
        load(4'b0010, 4'd9, 1'b1, 4'd3, 32'h0, 1'b0, 4'd0, 32'h77);
        bus.rs_full = 4'b0010;
        settle(); tick();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                bus.cdb_valid = 4'b0100;
                bus.cdb_tag[2*TAG_W +: TAG_W] = 4'd3;
                bus.cdb_value[2*XLEN +: XLEN] = 32'hDEADBEEF;
            end else begin
                bus.cdb_valid = '0;
            end
            settle();
            check("c_blocked_dv", 128'(bus.disp_valid), 128'(0));
            tick();
        end
        bus.rs_full = '0;
        settle();
        check("c_dv",    128'(bus.disp_valid), 128'(4'b0010));
        check("c_busy",  128'(bus.disp_src1_busy), 128'(0));
        check("c_val",   128'(bus.disp_src1_val), 128'(32'hDEADBEEF));
        check("c_stall", 128'(bus.stall_cnt), 128'(3));
        tick();

        // Two CDB ports match in the dispatch cycle: lowest port wins
        set_idle();
        load(4'b0100, 4'hA, 1'b0, 4'd7, 32'h55, 1'b1, 4'd7, 32'h0);
        settle(); tick();
        set_idle();
        bus.cdb_valid = 4'b1001;
        bus.cdb_tag[0 +: TAG_W] = 4'd7;
        bus.cdb_tag[3*TAG_W +: TAG_W] = 4'd7;
        bus.cdb_value[0 +: XLEN] = 32'h11;
        bus.cdb_value[3*XLEN +: XLEN] = 32'h22;
        settle();
        check("d_val",  128'(bus.disp_src2_val), 128'(32'h11));
        check("d_busy", 128'(bus.disp_src2_busy), 128'(0));
        check("d_src1", 128'(bus.disp_src1_val), 128'(32'h55));
        tick();
        set_idle();

        // Back-to-back streaming of 8 instructions
        n = 0;
        for (int k = 0; k < 8; k++) begin
            load(N_RS'(1 << (k % N_RS)), TAG_W'(k), 1'b0, '0, $urandom, 1'b0, '0, $urandom);
            settle();
            check("e_rdy", 128'(bus.in_ready), 128'(1));
            if (bus.disp_valid != '0) n++;
            tick();
        end
        set_idle();
        settle();
        if (bus.disp_valid != '0) n++;
        tick();
        check("e_count", 128'(n), 128'(8));

        // Flush while held and ROB full; a simultaneous in_valid is ignored
        load(4'b0001, 4'd2, 1'b0, '0, 32'h1, 1'b0, '0, 32'h2);
        settle(); tick();
        bus.rob_full = 1'b1;
        bus.flush = 1'b1;
        settle();
        check("f_alloc", 128'(bus.rob_alloc), 128'(0));
        check("f_dv",    128'(bus.disp_valid), 128'(0));
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        settle();
        check("f_empty_rdy", 128'(bus.in_ready), 128'(1));
        check("f_empty_dv",  128'(bus.disp_valid), 128'(0));
        tick();
        set_idle();

        // Zero-hot select is consumed silently
        load(4'b0000, 4'd4, 1'b0, '0, 32'h3, 1'b0, '0, 32'h4);
        settle(); tick();
        set_idle();
        settle();
        check("g_dv",    128'(bus.disp_valid), 128'(0));
        check("g_alloc", 128'(bus.rob_alloc), 128'(0));
        check("g_rdy",   128'(bus.in_ready), 128'(1));
        tick();
        settle();
        check("g_empty_rdy", 128'(bus.in_ready), 128'(1));
        tick();

        // Long stall drives stall_cnt to saturation
        load(4'b1000, 4'd6, 1'b1, 4'd6, 32'h0, 1'b0, '0, 32'h9);
        settle(); tick();
        set_idle();
        bus.rs_full = 4'b1000;
        repeat (14) begin settle(); tick(); end
        settle();
        check("h_sat", 128'(bus.stall_cnt), 128'(CNT_MAX));

        // Asynchronous reset mid-cycle while held with a busy operand
        #2;
        rst = 1'b1;
        #1;
        check("i_dv",    128'(bus.disp_valid), 128'(0));
        check("i_rdy",   128'(bus.in_ready), 128'(1));
        check("i_stall", 128'(bus.stall_cnt), 128'(0));
        m = '{default: '0};
        cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        set_idle();

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            int r;
            bus.in_valid = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, N_RS));
            bus.in_rs_sel = (r == N_RS) ? '0 : N_RS'(1 << r);
            bus.in_rob_tag = TAG_W'($urandom);
            bus.in_src1_busy = 1'($urandom_range(0, 1));
            bus.in_src2_busy = 1'($urandom_range(0, 1));
            bus.in_src1_tag = TAG_W'($urandom_range(0, 3));
            bus.in_src2_tag = TAG_W'($urandom_range(0, 3));
            bus.in_src1_val = $urandom;
            bus.in_src2_val = $urandom;
            bus.in_payload = {$urandom, $urandom, $urandom};
            bus.rob_full = ($urandom_range(0, 3) == 0);
            bus.rs_full = ($urandom_range(0, 1) != 0) ? N_RS'($urandom) : '0;
            bus.flush = ($urandom_range(0, 15) == 0);
            bus.cdb_valid = N_CDB'($urandom);
            for (int p = 0; p < N_CDB; p++) begin
                bus.cdb_tag[p*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 3));
                bus.cdb_value[p*XLEN +: XLEN] = $urandom;
            end
            settle();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
